timer_sequencer: RTL
====================

// Module: timer_sequencer
// PURPOSE
//  Initiator side of the 32-bit enable/status interval counter interface.
//  - Drives the counter's mode input and watches its status output.
//  - Host commands are single-cycle pulses: start, stop, capture, irq_ack.
//  - Produces expiry pulses, a sticky IRQ, an expiry tally and a captured count value.
//  - Sits between the CPU-facing register decode and the interval counter in the FPGA interface.
// PARAMETERS
//  CNT_W        32  width of counter_value / captured_value
//  EXP_W        16  width of expire_count (wraps modulo 2^EXP_W)
//  ARM_TIMEOUT  4   max cycles in ARM waiting for status=0 before arm_error
// PORTS
//  clk             in   1      system clock, rising edge
//  nreset          in   1      asynchronous, active-low reset
//  start           in   1      pulse: begin an interval (ignored unless IDLE)
//  stop            in   1      pulse: abort, return to IDLE (wins over start)
//  auto_reload     in   1      level: sampled in DONE; 1 = re-arm, 0 = go IDLE
//  capture         in   1      pulse: latch counter_value into captured_value
//  irq_ack         in   1      pulse: clear irq
//  counter_value   in   CNT_W  live count from the counter
//  counter_status  in   1      counter limit reached (registered; unreset, holds while mode=0)
//  counter_mode    out  1      counter enable; 0 clears the count
//  busy            out  1      1 in ARM/RUN/DONE
//  irq             out  1      sticky expiry interrupt
//  expire_pulse    out  1      one-cycle pulse per expiry
//  expire_count    out  EXP_W  number of expiries since reset
//  captured_value  out  CNT_W  last captured count
//  arm_error       out  1      sticky: counter failed to deassert status within ARM_TIMEOUT; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including counter_mode and every register.
//  All outputs are registered.
//  FSM:
//   IDLE: counter_mode=0.
//     start & !stop -> ARM; counter_mode=1 from the next cycle; arm_error cleared.
//   ARM: counter_mode=1. status is stale on entry, so it is sampled only after the first enabled edge.
//     status==0 -> RUN.
//     ARM_TIMEOUT cycles without status==0 -> IDLE, arm_error=1.
//   RUN: counter_mode=1.
//     status==1 -> DONE.
//   DONE (exactly 1 cycle): counter_mode=0 (clears count); expire_pulse=1; expire_count+=1 (wraps); irq=1.
//     auto_reload=1 -> ARM; auto_reload=0 -> IDLE.
//  stop in ARM/RUN/DONE -> IDLE next cycle; counter_mode=0.
//   - stop in DONE still completes that cycle's expiry bookkeeping.
//  start while busy: ignored, no side effects.
//  start and stop in the same cycle: stop wins.
//  irq: set and irq_ack in the same cycle -> irq stays 1 (set wins).
//  capture: captured_value <= counter_value one cycle later, in any state.
//   - Back-to-back captures update every cycle.
//  expire_count wraps 2^EXP_W-1 -> 0 with no flag.
//  nreset asserted mid-interval: immediate return to reset values.
//   - counter_mode drops asynchronously, so the counter clears too.
// STRUCTURE
//  timer_pkg:
//   - state enum {IDLE, ARM, RUN, DONE}, 2 bits
//   - ARM_TIMEOUT default
//   - EXP_W, CNT_W defaults
//  Single flat module; no sub-module needed.
//  The ARM timeout uses a small local down-counter, clog2(ARM_TIMEOUT)+1 bits.
// TESTING (bench counter model: same port behaviour, limit=5)
//  1. Reset, then start at cycle 10:
//     -> counter_mode=1 at cycle 11; expire_pulse once; irq=1.
//     -> expire_count=1; busy=0 one cycle after DONE.
//  2. auto_reload=1, start:
//     -> 3 consecutive expiries, expire_count=3.
//     -> counter_mode is low for exactly 1 cycle between intervals.
//  3. stop at count=3, plus start+stop in the same cycle from IDLE:
//     -> IDLE; counter_mode=0; no expire_pulse; expire_count unchanged.
//  4. Model holds status=1 after arming:
//     -> arm_error=1 after 4 ARM cycles; IDLE; next start clears arm_error.
//  5. irq_ack on the same cycle as DONE -> irq=1; irq_ack one cycle later -> irq=0.
//     capture at count=2 -> captured_value=2.
//  6. Preload expire_count=16'hFFFF, one expiry -> expire_count=0.
//     nreset pulsed mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and default sizes for the interval-counter initiator.
package timer_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int EXP_W_DEF       = 16;
  localparam int ARM_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/timer_sequencer.sv
// Initiator for the enable/status interval counter: arms it, waits for expiry,
// and keeps the expiry pulse, sticky IRQ, expiry tally and a captured count.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EXP_W       = EXP_W_DEF,
  parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             capture,
  input  logic             irq_ack,
  input  logic [CNT_W-1:0] counter_value,
  input  logic             counter_status,
  output logic             counter_mode,
  output logic             busy,
  output logic             irq,
  output logic             expire_pulse,
  output logic [EXP_W-1:0] expire_count,
  output logic [CNT_W-1:0] captured_value,
  output logic             arm_error
);

  localparam int              TMO_W    = $clog2(ARM_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ARM_TIMEOUT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             w_accept;
  logic             w_timeout;
  logic             w_expire;

  logic             r_mode;
  logic             r_busy;
  logic             r_irq;
  logic             r_pulse;
  logic             r_err;
  logic [EXP_W-1:0] r_ecount;
  logic [CNT_W-1:0] r_cap;

  // Next-state logic; status is stale on the first ARM cycle (r_tmo still at load value)
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_ARM;
          w_tmo_nxt   = TMO_LOAD;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        w_tmo_nxt = r_tmo - TMO_W'(1);
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_tmo != TMO_LOAD) && !counter_status) begin
          w_state_nxt = ST_RUN;
        end else if (r_tmo == TMO_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (counter_status) begin
          w_state_nxt = ST_DONE;
          w_expire    = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop || !auto_reload) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ARM;
          w_tmo_nxt   = TMO_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and ARM timeout counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Outputs registered from the state being entered, so they line up with it
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_mode   <= 1'b0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
      r_pulse  <= 1'b0;
      r_err    <= 1'b0;
      r_ecount <= '0;
      r_cap    <= '0;
    end else begin
      r_mode  <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_pulse <= w_expire;
      if (w_expire) begin
        r_ecount <= r_ecount + EXP_W'(1);
      end
      // An ack during the DONE cycle must not clear the interrupt just raised
      r_irq <= w_expire || (r_state == ST_DONE) || (r_irq && !irq_ack);
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (capture) begin
        r_cap <= counter_value;
      end
    end
  end

  assign counter_mode   = r_mode;
  assign busy           = r_busy;
  assign irq            = r_irq;
  assign expire_pulse   = r_pulse;
  assign expire_count   = r_ecount;
  assign captured_value = r_cap;
  assign arm_error      = r_err;

endmodule
